rgmii_phy_link_ctrl: RTL and testbench

- MDIO management master that sequences the PHY behind the GMII-to-RGMII converter.
- Periodically polls the PHY status register and drives the converter's speed_selection / duplex_mode configuration inputs.
- Also shares the single MDIO bus with a host register-access port (arbitrated).
- Sits beside the RGMII converter in the Ethernet subsystem, in the system clock domain.

---
 rtl/rgmii_phy_link_ctrl_if.sv | 20 ++
 rtl/rgmii_phy_link_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_rgmii_phy_link_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgmii_phy_link_ctrl_if.sv
// Host register-access port of the PHY link controller.
// The master drives requests; the slave (controller) returns ack and read data.
interface rgmii_phy_link_ctrl_if;
  logic        host_req;
  logic        host_we;
  logic [4:0]  host_reg;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;

  modport master (
    output host_req, host_we, host_reg, host_wdata,
    input  host_ack, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_reg, host_wdata,
    output host_ack, host_rdata
  );
endinterface

// File: rtl/rgmii_phy_link_ctrl.sv
// MDIO master that polls the PHY status register, drives the RGMII converter's speed/duplex
// configuration, and shares the MDIO bus with a host register-access port.
module rgmii_phy_link_ctrl #(
  parameter int unsigned MDC_DIV     = 25,
  parameter logic [4:0]  PHY_ADDR    = 5'd1,
  parameter logic [4:0]  STAT_REG    = 5'h11,
  parameter int unsigned POLL_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic                        mdc,
  output logic                        mdio_o,
  output logic                        mdio_oe,
  input  logic                        mdio_i,
  rgmii_phy_link_ctrl_if.slave        host,
  output logic [1:0]                  speed_selection,
  output logic                        duplex_mode,
  output logic                        link_up,
  output logic                        link_change,
  output logic                        busy
);

  localparam logic [7:0]  DivLast  = 8'(MDC_DIV - 1);
  localparam logic [31:0] PollLast = 32'(POLL_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_q, bit_d;
  logic [63:0] frame_q, frame_d;
  logic [15:0] rx_q, rx_d;
  logic        is_host_q, is_host_d;
  logic        we_q, we_d;
  logic        last_was_host_q, last_was_host_d;
  logic        poll_pending_q, poll_pending_d;
  logic [31:0] timer_q, timer_d;
  logic        mdc_q, mdc_d;
  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic [1:0]  speed_q, speed_d;
  logic        duplex_q, duplex_d;
  logic        link_q, link_d;
  logic        link_change_q, link_change_d;
  logic [15:0] rdata_q, rdata_d;
  logic        start;
  logic        frame_wr;
  logic [4:0]  frame_reg;

  always_comb begin
    state_d         = state_q;
    div_d           = div_q;
    bit_d           = bit_q;
    frame_d         = frame_q;
    rx_d            = rx_q;
    is_host_d       = is_host_q;
    we_d            = we_q;
    last_was_host_d = last_was_host_q;
    poll_pending_d  = poll_pending_q;
    timer_d         = timer_q;
    mdc_d           = mdc_q;
    mdio_o_d        = mdio_o_q;
    mdio_oe_d       = mdio_oe_q;
    speed_d         = speed_q;
    duplex_d        = duplex_q;
    link_d          = link_q;
    link_change_d   = 1'b0;
    rdata_d         = rdata_q;
    start           = 1'b0;
    frame_wr        = 1'b0;
    frame_reg       = STAT_REG;

    if (!poll_pending_q) begin
      if (timer_q == PollLast) poll_pending_d = 1'b1;
      else                     timer_d = timer_q + 32'd1;
    end

    case (state_q)
      StIdle: begin
        // A pending poll yields to at most one host frame.
        if (poll_pending_q && (last_was_host_q || !host.host_req)) begin
          start           = 1'b1;
          is_host_d       = 1'b0;
          last_was_host_d = 1'b0;
        end else if (host.host_req) begin
          start           = 1'b1;
          is_host_d       = 1'b1;
          last_was_host_d = 1'b1;
          frame_wr        = host.host_we;
          frame_reg       = host.host_reg;
        end
        if (start) begin
          frame_d   = {32'hFFFF_FFFF, 2'b01, frame_wr ? 2'b01 : 2'b10, PHY_ADDR, frame_reg,
                       frame_wr ? 2'b10 : 2'b00, frame_wr ? host.host_wdata : 16'h0000};
          we_d      = frame_wr;
          bit_d     = 6'd0;
          div_d     = 8'd0;
          mdc_d     = 1'b0;
          mdio_o_d  = frame_d[63];
          mdio_oe_d = 1'b1;
          state_d   = StShift;
        end
      end
      StShift: begin
        if (div_q == DivLast) begin
          div_d = 8'd0;
          if (!mdc_q) begin
            mdc_d = 1'b1;
            if (bit_q >= 6'd48) rx_d = {rx_q[14:0], mdio_i};
          end else if (bit_q == 6'd63) begin
            mdc_d     = 1'b0;
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
            state_d   = StDone;
            if (is_host_q) begin
              if (!we_q) rdata_d = rx_q;
            end else begin
              timer_d        = 32'd0;
              poll_pending_d = 1'b0;
              link_d         = rx_q[10];
              link_change_d  = rx_q[10] ^ link_q;
              if (rx_q[10]) begin
                duplex_d = rx_q[13];
                if (rx_q[15:14] != 2'b11) speed_d = rx_q[15:14];
              end
            end
          end else begin
            mdc_d     = 1'b0;
            bit_d     = bit_q + 6'd1;
            mdio_o_d  = frame_q[6'd62 - bit_q];
            // Reads release the line from the turnaround onward.
            mdio_oe_d = we_q || (bit_q < 6'd45);
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      div_q           <= 8'd0;
      bit_q           <= 6'd0;
      frame_q         <= 64'd0;
      rx_q            <= 16'd0;
      is_host_q       <= 1'b0;
      we_q            <= 1'b0;
      last_was_host_q <= 1'b0;
      poll_pending_q  <= 1'b1;
      timer_q         <= 32'd0;
      mdc_q           <= 1'b0;
      mdio_o_q        <= 1'b1;
      mdio_oe_q       <= 1'b0;
      speed_q         <= 2'b10;
      duplex_q        <= 1'b1;
      link_q          <= 1'b0;
      link_change_q   <= 1'b0;
      rdata_q         <= 16'd0;
    end else begin
      state_q         <= state_d;
      div_q           <= div_d;
      bit_q           <= bit_d;
      frame_q         <= frame_d;
      rx_q            <= rx_d;
      is_host_q       <= is_host_d;
      we_q            <= we_d;
      last_was_host_q <= last_was_host_d;
      poll_pending_q  <= poll_pending_d;
      timer_q         <= timer_d;
      mdc_q           <= mdc_d;
      mdio_o_q        <= mdio_o_d;
      mdio_oe_q       <= mdio_oe_d;
      speed_q         <= speed_d;
      duplex_q        <= duplex_d;
      link_q          <= link_d;
      link_change_q   <= link_change_d;
      rdata_q         <= rdata_d;
    end
  end

  assign mdc             = mdc_q;
  assign mdio_o          = mdio_o_q;
  assign mdio_oe         = mdio_oe_q;
  assign speed_selection = speed_q;
  assign duplex_mode     = duplex_q;
  assign link_up         = link_q;
  assign link_change     = link_change_q;
  assign busy            = (state_q != StIdle);
  assign host.host_ack   = (state_q == StDone) && is_host_q;
  assign host.host_rdata = rdata_q;

endmodule

// File: tb/tb_rgmii_phy_link_ctrl.sv
// Bench for rgmii_phy_link_ctrl: behavioural MDIO PHY, status-poll table, random polls and
// host accesses against a scoreboard, arbitration and mid-frame reset sequences.
module tb_rgmii_phy_link_ctrl;
  localparam int unsigned MDC_DIV     = 2;
  localparam int unsigned POLL_CYCLES = 200;
  localparam int          FRAME_CYC   = 128 * MDC_DIV + 1;
  localparam int          BOUND       = 4000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       mdc, mdio_o, mdio_oe;
  logic       mdio_i = 1'b1;
  logic [1:0] speed_selection;
  logic       duplex_mode, link_up, link_change, busy;

  rgmii_phy_link_ctrl_if host_if ();

  rgmii_phy_link_ctrl #(
    .MDC_DIV     (MDC_DIV),
    .PHY_ADDR    (5'd1),
    .STAT_REG    (5'h11),
    .POLL_CYCLES (POLL_CYCLES)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .mdc             (mdc),
    .mdio_o          (mdio_o),
    .mdio_oe         (mdio_oe),
    .mdio_i          (mdio_i),
    .host            (host_if),
    .speed_selection (speed_selection),
    .duplex_mode     (duplex_mode),
    .link_up         (link_up),
    .link_change     (link_change),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic       is_write;
    logic [4:0] regad;
    logic [15:0] data;
  } frame_t;

  typedef struct {
    logic [15:0] stat;
    logic [1:0]  speed;
    logic        duplex;
    logic        link;
    int          lc;
  } poll_vec_t;

  logic [15:0] phy_regs [32];
  logic [15:0] sb_regs  [32];
  logic [15:0] phy_stat;
  frame_t      frames[$];
  int          lc_pulses  = 0;
  int          ack_cycles = 0;

  always @(negedge clk) begin
    if (link_change === 1'b1) lc_pulses++;
    if (host_if.host_ack === 1'b1) ack_cycles++;
  end

  // Behavioural PHY: records every frame bit on mdc rising and answers reads.
  initial begin : phy_model
    logic [63:0] bits, oes;
    logic [15:0] rd;
    logic        aborted;
    frame_t      f;
    forever begin
      @(posedge busy);
      bits = '0; oes = '0; rd = 16'hFFFF; aborted = 1'b0;
      for (int k = 0; k < 64; k++) begin
        @(posedge mdc or negedge reset_n);
        if (!reset_n) begin
          aborted = 1'b1;
          break;
        end
        bits[63-k] = mdio_o;
        oes[63-k]  = mdio_oe;
        if (k == 45) rd = (bits[22:18] == 5'h11) ? phy_stat : phy_regs[bits[22:18]];
        if (k >= 47 && k < 63 && bits[29:28] == 2'b10) begin
          #1 mdio_i = rd[62-k];
        end else if (k == 63) begin
          #1 mdio_i = 1'b1;
        end
      end
      if (aborted) begin
        mdio_i = 1'b1;
        continue;
      end
      chk("preamble", bits[63:32], 32'hFFFF_FFFF);
      chk("st", 32'(bits[31:30]), 32'h1);
      chk("phyad", 32'(bits[27:23]), 32'h1);
      chk("hdr_oe", 32'(&oes[63:18]), 32'h1);
      f.is_write = (bits[29:28] == 2'b01);
      f.regad    = bits[22:18];
      if (f.is_write) begin
        chk("wr_ta", 32'(bits[17:16]), 32'h2);
        chk("wr_oe", 32'(&oes[17:0]), 32'h1);
        phy_regs[f.regad] = bits[15:0];
        f.data = bits[15:0];
      end else begin
        chk("rd_op", 32'(bits[29:28]), 32'h2);
        chk("rd_oe", 32'(|oes[17:0]), 32'h0);
        f.data = rd;
      end
      frames.push_back(f);
    end
  end

  // Returns once the target frame count is reached and the controller is idle again.
  task automatic wait_frames(input int target, input string name);
    int t = 0;
    while ((frames.size() < target || busy !== 1'b0) && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (t >= BOUND) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, frames %0d, required %0d", name, frames.size(), target);
    end
  endtask

  task automatic host_xfer(input logic we, input logic [4:0] regad, input logic [15:0] wdata,
                           output logic [15:0] rdata);
    int t = 0;
    int a0;
    a0 = ack_cycles;
    host_if.host_we    = we;
    host_if.host_reg   = regad;
    host_if.host_wdata = wdata;
    host_if.host_req   = 1'b1;
    while (host_if.host_ack !== 1'b1 && t < BOUND) begin
      @(negedge clk);
      t++;
    end
    if (t >= BOUND) begin
      checks++;
      errors++;
      $display("FAIL host_ack: timeout, got no ack, required one");
    end
    rdata            = host_if.host_rdata;
    host_if.host_req = 1'b0;
    @(negedge clk);
    chk("ack_width", 32'(ack_cycles - a0), 32'h1);
    chk("oe_after_ack", 32'(mdio_oe), 32'h0);
  endtask

  logic [1:0] m_speed;
  logic       m_duplex, m_link;

  task automatic model_poll(input logic [15:0] s, output int lc);
    lc = (s[10] != m_link) ? 1 : 0;
    if (s[10]) begin
      m_duplex = s[13];
      if (s[15:14] != 2'b11) m_speed = s[15:14];
    end
    m_link = s[10];
  endtask

  task automatic check_poll_outputs(input string tag, input int lc0, input int lc_exp);
    chk({tag, "_speed"}, 32'(speed_selection), 32'(m_speed));
    chk({tag, "_duplex"}, 32'(duplex_mode), 32'(m_duplex));
    chk({tag, "_link"}, 32'(link_up), 32'(m_link));
    chk({tag, "_lc"}, 32'(lc_pulses - lc0), 32'(lc_exp));
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : main
    poll_vec_t   vecs[6];
    int          n, lc0, lc_exp, i0, npoll;
    logic [15:0] rdata, s, wd;
    logic [4:0]  ra;
    logic        we;

    vecs[0] = '{16'h6400, 2'b01, 1'b1, 1'b1, 0};
    vecs[1] = '{16'hC400, 2'b01, 1'b0, 1'b1, 0};
    vecs[2] = '{16'h0000, 2'b01, 1'b0, 1'b0, 1};
    vecs[3] = '{16'hE000, 2'b01, 1'b0, 1'b0, 0};
    vecs[4] = '{16'h0400, 2'b00, 1'b0, 1'b1, 1};
    vecs[5] = '{16'hA400, 2'b10, 1'b1, 1'b1, 0};

    for (int r = 0; r < 32; r++) begin
      phy_regs[r] = 16'(r * 16'h0101);
      sb_regs[r]  = phy_regs[r];
    end
    phy_regs[2] = 16'h001C;
    sb_regs[2]  = 16'h001C;
    phy_stat = 16'hAC00;
    host_if.host_req = 1'b0; host_if.host_we = 1'b0;
    host_if.host_reg = 5'd0; host_if.host_wdata = 16'd0;

    repeat (3) @(negedge clk);
    chk("rst_mdc", 32'(mdc), 32'h0);
    chk("rst_oe", 32'(mdio_oe), 32'h0);
    chk("rst_mdio_o", 32'(mdio_o), 32'h1);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ack", 32'(host_if.host_ack), 32'h0);
    chk("rst_rdata", 32'(host_if.host_rdata), 32'h0);
    chk("rst_speed", 32'(speed_selection), 32'h2);
    chk("rst_duplex", 32'(duplex_mode), 32'h1);
    chk("rst_link", 32'(link_up), 32'h0);
    chk("rst_lc", 32'(link_change), 32'h0);

    // First poll: starts right after release and lasts 128*MDC_DIV+1 cycles.
    m_speed = 2'b10; m_duplex = 1'b1; m_link = 1'b0;
    lc0 = lc_pulses;
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_start", 32'(busy), 32'h1);
    n = 0;
    while (busy === 1'b1 && n < BOUND) begin
      n++;
      @(negedge clk);
    end
    chk("frame_cycles", 32'(n), 32'(FRAME_CYC));
    wait_frames(1, "first_poll");
    chk("first_reg", 32'(frames[0].regad), 32'h11);
    chk("first_rd", 32'(frames[0].is_write), 32'h0);
    model_poll(16'hAC00, lc_exp);
    check_poll_outputs("first", lc0, lc_exp);

    foreach (vecs[i]) begin
      phy_stat = vecs[i].stat;
      lc0 = lc_pulses;
      wait_frames(frames.size() + 1, "vec_poll");
      chk("vec_speed", 32'(speed_selection), 32'(vecs[i].speed));
      chk("vec_duplex", 32'(duplex_mode), 32'(vecs[i].duplex));
      chk("vec_link", 32'(link_up), 32'(vecs[i].link));
      chk("vec_lc", 32'(lc_pulses - lc0), 32'(vecs[i].lc));
    end
    m_speed = 2'b10; m_duplex = 1'b1; m_link = 1'b1;

    for (int i = 0; i < 10; i++) begin
      s = 16'($urandom);
      phy_stat = s;
      lc0 = lc_pulses;
      wait_frames(frames.size() + 1, "rand_poll");
      model_poll(s, lc_exp);
      check_poll_outputs("rand", lc0, lc_exp);
    end

    host_xfer(1'b1, 5'h00, 16'h1140, rdata);
    sb_regs[0] = 16'h1140;
    chk("wr_reg", 32'(frames[$].regad), 32'h0);
    chk("wr_data", 32'(frames[$].data), 32'h1140);
    chk("wr_kind", 32'(frames[$].is_write), 32'h1);
    chk("wr_rdata_held", 32'(rdata), 32'h0);
    host_xfer(1'b0, 5'h02, 16'h0000, rdata);
    chk("rd_rdata", 32'(rdata), 32'h001C);
    chk("rd_reg", 32'(frames[$].regad), 32'h2);
    host_xfer(1'b1, 5'h03, 16'hBEEF, rdata);
    sb_regs[3] = 16'hBEEF;
    chk("rdata_hold", 32'(host_if.host_rdata), 32'h001C);

    for (int i = 0; i < 6; i++) begin
      we = 1'($urandom);
      ra = 5'($urandom_range(0, 16));
      wd = 16'($urandom);
      host_xfer(we, ra, wd, rdata);
      if (we) sb_regs[ra] = wd;
      else    chk("rand_rd", 32'(rdata), 32'(sb_regs[ra]));
    end

    // Host request held high: host and poll frames must alternate.
    i0 = frames.size();
    host_if.host_we = 1'b0; host_if.host_reg = 5'h02; host_if.host_req = 1'b1;
    wait_frames(i0 + 8, "alt_frames");
    n = 0;
    while (host_if.host_ack !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    host_if.host_req = 1'b0;
    wait_frames(frames.size(), "alt_idle");
    npoll = 0;
    for (int k = i0; k < frames.size(); k++) begin
      if (frames[k].regad == 5'h11) npoll++;
      if (k > i0) chk("alternate", 32'(frames[k].regad == 5'h11),
                      32'(frames[k-1].regad != 5'h11));
    end
    chk("alt_polls", 32'(npoll >= 3), 32'h1);

    // Reset asserted in the high phase of bit 40.
    phy_stat = 16'h6400;
    n = 0;
    while (busy !== 1'b1 && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    repeat (162) @(negedge clk);
    chk("pre_rst_mdc", 32'(mdc), 32'h1);
    chk("pre_rst_oe", 32'(mdio_oe), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_mdc", 32'(mdc), 32'h0);
    chk("mid_rst_oe", 32'(mdio_oe), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_mdio_o", 32'(mdio_o), 32'h1);
    chk("mid_rst_speed", 32'(speed_selection), 32'h2);
    chk("mid_rst_link", 32'(link_up), 32'h0);
    m_speed = 2'b10; m_duplex = 1'b1; m_link = 1'b0;
    repeat (2) @(negedge clk);
    lc0 = lc_pulses;
    reset_n = 1'b1;
    @(negedge clk);
    chk("rerun_start", 32'(busy), 32'h1);
    wait_frames(frames.size() + 1, "rerun_poll");
    model_poll(16'h6400, lc_exp);
    check_poll_outputs("rerun", lc0, lc_exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
